multi_mode_counter: RTL and testbench
=====================================

MULTI_MODE_COUNTER -- requirements
Module: multi_mode_counter

Interface
REQ-001 SHALL have parameter N, default 6: counter and bound width in bits.
REQ-002 SHALL have parameter STEP, default 1: increment/decrement per counted cycle, 1 <= STEP < 2^N.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begin a count run; sampled only in IDLE.
REQ-007 stop  input  1  abort run; return to IDLE.
REQ-008 enable  input  1  count qualifier; low pauses the count in RUN.
REQ-009 dir  input  1  0 = up, 1 = down; latched at start.
REQ-010 mode  input  2  00 wrap, 01 one-shot, 10 saturate, 11 reserved (treated as one-shot); latched at start.
REQ-011 init_val  input  N  start value; latched at start.
REQ-012 limit  input  N  terminal value; latched at start.
REQ-013 count  output  N  current count, registered.
REQ-014 busy  output  1  high in RUN or SAT.
REQ-015 done  output  1  registered one-cycle pulse on terminal event.
REQ-016 tc  output  1  combinational: busy && count == latched limit.
REQ-017 err  output  1  registered one-cycle pulse on illegal start.

Function
REQ-018 FSM SHALL have states IDLE, RUN, SAT.
REQ-019 IDLE, start=1, legal: load count<=init_val; latch dir, mode, limit into shadow registers; go to RUN next edge.
REQ-020 Start is illegal when (dir=0 && init_val > limit) or (dir=1 && init_val < limit). An illegal start SHALL pulse err for one cycle, stay in IDLE, and leave count unchanged.
REQ-021 start SHALL be ignored in RUN and SAT.
REQ-022 RUN, enable=0: count and state hold.
REQ-023 RUN, enable=1, count != limit_r: up: count <= min(count+STEP, limit_r); down: count <= max(count-STEP, limit_r). Arithmetic SHALL use N+1 bits, so no overflow or underflow wrap past the bound.
REQ-024 Terminal event: RUN, enable=1, count == limit_r. done SHALL be high for exactly the cycle after that edge.
REQ-025 Terminal event, wrap: count <= init_r; stay in RUN.
REQ-026 Terminal event, one-shot: count holds; go to IDLE.
REQ-027 Terminal event, saturate: count holds; go to SAT. SAT holds count, with no further done pulses, until stop.
REQ-028 stop=1 in RUN or SAT: go to IDLE next edge; count holds; no done.
REQ-029 stop and terminal event on the same edge: stop wins, no done.
REQ-030 init_val == limit on a legal start: first enabled RUN cycle is a terminal event.
REQ-031 stop in IDLE SHALL have no effect; start and stop together in IDLE: stop wins, no run.

Reset
REQ-032 rst low SHALL asynchronously force: state IDLE, count=0, done=0, err=0, shadow registers=0; hence busy=0, tc=0.
REQ-033 Reset asserted mid-run SHALL abort without a done pulse; after deassertion the block waits for a new start.

Verification (N=6)
REQ-034 STEP=1, up, one-shot, init 3, limit 7, enable=1 -> count 3,4,5,6,7; done one cycle after the next edge; busy falls; count stays 7.
REQ-035 STEP=1, up, wrap, init 2, limit 4 -> count 2,3,4,2,3,4,2...; done pulses once per return to 2; busy stays 1 until stop.
REQ-036 STEP=3, down, one-shot, init 10, limit 0 -> count 10,7,4,1,0 (clamped); then done pulse; then IDLE.
REQ-037 up, init 9, limit 5, start -> err one-cycle pulse, busy=0, count unchanged.
REQ-038 STEP=1, saturate, init 0, limit 3, enable toggling 1,0,1... -> count advances only on enable=1 cycles; holds 3 in SAT with tc=1 and a single done; stop -> IDLE.
REQ-039 Mid-run rst low at count=5 -> count=0, busy=0 immediately without a clock; no done; stop and terminal event on the same edge -> no done.

Source files
------------

// File: rtl/multi_mode_counter.sv
// Multi-mode up/down counter with wrap, one-shot and saturate behaviour.
// Direction, mode, start value and bound are captured at start so a run is immune to input changes.
module multi_mode_counter #(
    parameter int N    = 6,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         enable,
    input  logic         dir,
    input  logic [1:0]   mode,
    input  logic [N-1:0] init_val,
    input  logic [N-1:0] limit,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done,
    output logic         tc,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        SAT  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_SAT  = 2'b10;
    localparam logic [N:0] STEP_EXT  = (N+1)'(STEP);

    state_t       state;
    state_t       state_next;
    logic [N-1:0] count_next;
    logic         done_next;
    logic         err_next;
    logic         load;
    logic         illegal;

    logic         dir_r;
    logic [1:0]   mode_r;
    logic [N-1:0] limit_r;
    logic [N-1:0] init_r;

    // One extra bit keeps the step from wrapping past either end of the range.
    logic [N:0]   up_sum;
    logic [N:0]   down_floor;

    assign up_sum     = {1'b0, count} + STEP_EXT;
    assign down_floor = {1'b0, limit_r} + STEP_EXT;
    assign illegal    = dir ? (init_val < limit) : (init_val > limit);

    always_comb begin
        state_next = state;
        count_next = count;
        done_next  = 1'b0;
        err_next   = 1'b0;
        load       = 1'b0;

        case (state)
            IDLE: begin
                if (!stop && start) begin
                    if (illegal) begin
                        err_next = 1'b1;
                    end else begin
                        load       = 1'b1;
                        count_next = init_val;
                        state_next = RUN;
                    end
                end
            end

            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (enable) begin
                    if (count == limit_r) begin
                        done_next = 1'b1;
                        case (mode_r)
                            MODE_WRAP: count_next = init_r;
                            MODE_SAT:  state_next = SAT;
                            default:   state_next = IDLE;
                        endcase
                    end else if (!dir_r) begin
                        count_next = (up_sum > {1'b0, limit_r}) ? limit_r : up_sum[N-1:0];
                    end else begin
                        // count - STEP < limit exactly when count < limit + STEP
                        count_next = ({1'b0, count} < down_floor) ? limit_r
                                                                  : count - STEP_EXT[N-1:0];
                    end
                end
            end

            SAT: begin
                if (stop) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            dir_r   <= 1'b0;
            mode_r  <= '0;
            limit_r <= '0;
            init_r  <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            done  <= done_next;
            err   <= err_next;
            if (load) begin
                dir_r   <= dir;
                mode_r  <= mode;
                limit_r <= limit;
                init_r  <= init_val;
            end
        end
    end

    assign busy = (state == RUN) || (state == SAT);
    assign tc   = busy && (count == limit_r);

endmodule

// File: tb/tb_multi_mode_counter.sv
// Scoreboard bench for multi_mode_counter: two instances (STEP=1 and STEP=3) share the stimulus.
// Expected outputs are queued as each cycle is driven and popped once the edge has been taken.
module tb_multi_mode_counter;

    typedef struct packed {
        logic [5:0] count;
        logic       busy;
        logic       done;
        logic       tc;
        logic       err;
    } obs_t;

    typedef struct packed {
        logic st;
        logic sp;
        logic en;
        obs_t exp;
    } step_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       enable;
    logic       dir;
    logic [1:0] mode;
    logic [5:0] init_val;
    logic [5:0] limit;

    logic [5:0] count_1, count_3;
    logic       busy_1, done_1, tc_1, err_1;
    logic       busy_3, done_3, tc_3, err_3;

    obs_t exp_q[$];
    int   checks;
    int   errors;

    multi_mode_counter #(.N(6), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .enable(enable),
        .dir(dir), .mode(mode), .init_val(init_val), .limit(limit),
        .count(count_1), .busy(busy_1), .done(done_1), .tc(tc_1), .err(err_1)
    );

    multi_mode_counter #(.N(6), .STEP(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .enable(enable),
        .dir(dir), .mode(mode), .init_val(init_val), .limit(limit),
        .count(count_3), .busy(busy_3), .done(done_3), .tc(tc_3), .err(err_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t obs1();
        return {count_1, busy_1, done_1, tc_1, err_1};
    endfunction

    function automatic obs_t obs3();
        return {count_3, busy_3, done_3, tc_3, err_3};
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("count=%0d busy=%b done=%b tc=%b err=%b", o.count, o.busy, o.done, o.tc, o.err);
    endfunction

    function automatic step_t mk(logic st, logic sp, logic en, int c,
                                 logic b, logic d, logic t, logic e);
        step_t s;
        s.st  = st;
        s.sp  = sp;
        s.en  = en;
        s.exp = {6'(c), b, d, t, e};
        return s;
    endfunction

    // Apply one cycle of control inputs, queue its expected outcome, then step past the edge.
    task automatic drive(input step_t s);
        start  = s.st;
        stop   = s.sp;
        enable = s.en;
        exp_q.push_back(s.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        start  = 1'b0;
        stop   = 1'b0;
        rst    = 1'b0;
        #2;
        rst    = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, e;
        rst = 1'b0;
        #1;
        exp_q.push_back(obs_t'(0));
        exp_q.push_back(obs_t'(0));
        got = obs1();
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL reset_dut1: got %s, expected %s", fmt(got), fmt(e));
        end
        got = obs3();
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL reset_dut3: got %s, expected %s", fmt(got), fmt(e));
        end
        #2;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(mk(0, 0, 1, 0, 0, 0, 0, 0));
            got = obs1();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL reset_idle step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_oneshot_up();
        step_t seq[$];
        obs_t  got, e;
        dir = 1'b0; mode = 2'b01; init_val = 6'd3; limit = 6'd7;
        pulse_reset();
        seq.push_back(mk(1, 0, 1, 3, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 4, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 5, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 6, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 7, 1, 0, 1, 0));
        seq.push_back(mk(0, 0, 1, 7, 0, 1, 0, 0));
        seq.push_back(mk(0, 0, 1, 7, 0, 0, 0, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            got = obs1();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL oneshot_up step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_wrap();
        step_t seq[$];
        obs_t  got, e;
        int    c;
        dir = 1'b0; mode = 2'b00; init_val = 6'd2; limit = 6'd4;
        pulse_reset();
        seq.push_back(mk(1, 0, 1, 2, 1, 0, 0, 0));
        for (int k = 1; k <= 8; k++) begin
            c = 2 + (k % 3);
            seq.push_back(mk(0, 0, 1, c, 1, (k % 3 == 0), (c == 4), 0));
        end
        // stop lands on a terminal edge (count 4): stop wins and no done follows
        seq.push_back(mk(0, 1, 1, 4, 0, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 4, 0, 0, 0, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            got = obs1();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL wrap step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_step3_clamp();
        step_t seq[$];
        obs_t  got, e;
        dir = 1'b1; mode = 2'b01; init_val = 6'd10; limit = 6'd0;
        pulse_reset();
        seq.push_back(mk(1, 0, 1, 10, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1,  7, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1,  4, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1,  1, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1,  0, 1, 0, 1, 0));
        seq.push_back(mk(0, 0, 1,  0, 0, 1, 0, 0));
        seq.push_back(mk(0, 0, 1,  0, 0, 0, 0, 0));
        seq.push_back(mk(1, 0, 1, 61, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 63, 1, 0, 1, 0));
        seq.push_back(mk(0, 0, 1, 63, 0, 1, 0, 0));
        foreach (seq[i]) begin
            if (i == 7) begin
                dir = 1'b0; init_val = 6'd61; limit = 6'd63;
            end
            drive(seq[i]);
            got = obs3();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL step3_clamp step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_illegal_start();
        step_t seq[$];
        obs_t  got, e;
        dir = 1'b0; mode = 2'b11; init_val = 6'd5; limit = 6'd5;
        pulse_reset();
        seq.push_back(mk(1, 0, 1, 5, 1, 0, 1, 0));
        seq.push_back(mk(0, 0, 1, 5, 0, 1, 0, 0));
        seq.push_back(mk(1, 0, 1, 5, 0, 0, 0, 1));
        seq.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0));
        seq.push_back(mk(1, 0, 1, 5, 0, 0, 0, 1));
        seq.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0));
        foreach (seq[i]) begin
            if (i == 2) begin
                init_val = 6'd9; limit = 6'd5;
            end
            if (i == 4) begin
                dir = 1'b1; init_val = 6'd2; limit = 6'd6;
            end
            drive(seq[i]);
            got = obs1();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL illegal_start step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_saturate();
        step_t seq[$];
        obs_t  got, e;
        dir = 1'b0; mode = 2'b10; init_val = 6'd0; limit = 6'd3;
        pulse_reset();
        seq.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 2, 1, 0, 0, 0));
        seq.push_back(mk(1, 0, 0, 2, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 3, 1, 0, 1, 0));
        seq.push_back(mk(0, 0, 0, 3, 1, 0, 1, 0));
        seq.push_back(mk(0, 0, 1, 3, 1, 1, 1, 0));
        seq.push_back(mk(0, 0, 0, 3, 1, 0, 1, 0));
        seq.push_back(mk(1, 0, 1, 3, 1, 0, 1, 0));
        seq.push_back(mk(0, 0, 1, 3, 1, 0, 1, 0));
        seq.push_back(mk(0, 1, 1, 3, 0, 0, 0, 0));
        seq.push_back(mk(0, 1, 1, 3, 0, 0, 0, 0));
        seq.push_back(mk(1, 1, 1, 3, 0, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0));
        foreach (seq[i]) begin
            if (i == 1) begin
                init_val = 6'd1;
            end
            drive(seq[i]);
            got = obs1();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL saturate step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_async_reset();
        step_t seq[$];
        obs_t  got, e;
        dir = 1'b0; mode = 2'b01; init_val = 6'd3; limit = 6'd20;
        pulse_reset();
        seq.push_back(mk(1, 0, 1, 3, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 4, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 5, 1, 0, 0, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            got = obs1();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL async_reset run step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
        // Mid-cycle, no clock edge between asserting reset and sampling.
        #2;
        rst = 1'b0;
        exp_q.push_back(obs_t'(0));
        #1;
        got = obs1();
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL async_reset immediate: got %s, expected %s", fmt(got), fmt(e));
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 0, 1, 0, 0, 0, 0, 0));
            got = obs1();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL async_reset after step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        enable   = 1'b1;
        dir      = 1'b0;
        mode     = 2'b00;
        init_val = '0;
        limit    = '0;

        test_reset();
        $display("[TB] reset checks complete");
        test_oneshot_up();
        test_wrap();
        test_step3_clamp();
        test_illegal_start();
        test_saturate();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
